mig_app_bram_responder: RTL and testbench

//  Synthesizable stand-in for the DDR4 MIG user (app_*) interface: the responder end that the mem_burst

---
 rtl/mig_app_bram_responder.sv | 202 ++++++++++++++++++++
 tb/tb_mig_app_bram_responder.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mig_app_bram_responder.sv
// BRAM-backed responder for the DDR4 MIG app_* user interface.
// Write commands and write data queue independently and commit pairwise; reads wait behind earlier writes.
module mig_app_bram_responder #(
  parameter int MEM_DATA_BITS    = 256,
  parameter int MEM_IF_ADDR_BITS = 29,
  parameter int DEPTH_LOG2       = 10,
  parameter int RD_LATENCY       = 4,
  parameter int CALIB_CYCLES     = 64,
  parameter int RDY_STALL_PERIOD = 0
) (
  input  logic                          mem_clk,
  input  logic                          rst,
  output logic                          init_calib_complete,
  input  logic [MEM_IF_ADDR_BITS-1:0]   app_addr,
  input  logic [2:0]                    app_cmd,
  input  logic                          app_en,
  output logic                          app_rdy,
  input  logic [MEM_DATA_BITS-1:0]      app_wdf_data,
  input  logic [MEM_DATA_BITS/8-1:0]    app_wdf_mask,
  input  logic                          app_wdf_wren,
  input  logic                          app_wdf_end,
  output logic                          app_wdf_rdy,
  output logic [MEM_DATA_BITS-1:0]      app_rd_data,
  output logic                          app_rd_data_valid,
  output logic                          app_rd_data_end
);

  localparam int BYTES = MEM_DATA_BITS / 8;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = $clog2(CALIB_CYCLES + 1);
  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  // app_wdf_end carries no information for single-beat writes; address bits outside the index alias
  logic unused_ok;
  assign unused_ok = ^{app_wdf_end, app_addr};

  // calibration delay: down-counter, model ready at terminal count
  logic [CW-1:0] calib_cnt;
  logic          calib;

  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst)                   calib_cnt <= CW'(CALIB_CYCLES);
    else if (calib_cnt != '0)  calib_cnt <= calib_cnt - CW'(1);
  end

  assign calib               = (calib_cnt == '0);
  assign init_calib_complete = calib;

  logic stall_cycle;

  generate
    if (RDY_STALL_PERIOD > 0) begin : g_stall
      localparam int SW = (RDY_STALL_PERIOD > 1) ? $clog2(RDY_STALL_PERIOD) : 1;
      logic [SW-1:0] stall_cnt;

      always_ff @(posedge mem_clk or posedge rst) begin
        if (rst)                   stall_cnt <= SW'(RDY_STALL_PERIOD - 1);
        else if (stall_cnt == '0)  stall_cnt <= SW'(RDY_STALL_PERIOD - 1);
        else                       stall_cnt <= stall_cnt - SW'(1);
      end

      assign stall_cycle = (stall_cnt == '0);
    end else begin : g_no_stall
      assign stall_cycle = 1'b0;
    end
  endgenerate

  logic [DEPTH_LOG2-1:0] acc_idx;
  logic                  cmd_acc, wr_push, rd_acc, dat_push, commit;

  logic [DEPTH_LOG2-1:0] wcmd_mem [4];
  logic [1:0]            wcmd_wp, wcmd_rp;
  logic [2:0]            wcmd_cnt;
  logic                  wcmd_full, wcmd_empty;

  logic [MEM_DATA_BITS-1:0] wdat_mem [4];
  logic [BYTES-1:0]         wmsk_mem [4];
  logic [1:0]               wdat_wp, wdat_rp;
  logic [2:0]               wdat_cnt;
  logic                     wdat_full, wdat_empty;

  logic                  rd_hold_vld;
  logic [DEPTH_LOG2-1:0] rd_hold_idx;
  logic                  rd_direct, hold_issue, issue;
  logic [DEPTH_LOG2-1:0] issue_idx;

  assign acc_idx    = app_addr[DEPTH_LOG2+2:3];
  assign wcmd_full  = (wcmd_cnt == 3'd4);
  assign wcmd_empty = (wcmd_cnt == 3'd0);
  assign wdat_full  = (wdat_cnt == 3'd4);
  assign wdat_empty = (wdat_cnt == 3'd0);

  assign app_rdy     = calib & ~wcmd_full & ~rd_hold_vld & ~stall_cycle;
  assign app_wdf_rdy = calib & ~wdat_full;

  assign cmd_acc  = app_en & app_rdy;
  assign wr_push  = cmd_acc & (app_cmd == CMD_WR);
  assign rd_acc   = cmd_acc & (app_cmd == CMD_RD);
  assign dat_push = app_wdf_wren & app_wdf_rdy;
  assign commit   = ~wcmd_empty & ~wdat_empty;

  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      wcmd_wp  <= '0;
      wcmd_rp  <= '0;
      wcmd_cnt <= '0;
    end else begin
      if (wr_push) wcmd_wp <= wcmd_wp + 2'd1;
      if (commit)  wcmd_rp <= wcmd_rp + 2'd1;
      case ({wr_push, commit})
        2'b10:   wcmd_cnt <= wcmd_cnt + 3'd1;
        2'b01:   wcmd_cnt <= wcmd_cnt - 3'd1;
        default: wcmd_cnt <= wcmd_cnt;
      endcase
    end
  end

  always_ff @(posedge mem_clk) begin
    if (wr_push) wcmd_mem[wcmd_wp] <= acc_idx;
  end

  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      wdat_wp  <= '0;
      wdat_rp  <= '0;
      wdat_cnt <= '0;
    end else begin
      if (dat_push) wdat_wp <= wdat_wp + 2'd1;
      if (commit)   wdat_rp <= wdat_rp + 2'd1;
      case ({dat_push, commit})
        2'b10:   wdat_cnt <= wdat_cnt + 3'd1;
        2'b01:   wdat_cnt <= wdat_cnt - 3'd1;
        default: wdat_cnt <= wdat_cnt;
      endcase
    end
  end

  always_ff @(posedge mem_clk) begin
    if (dat_push) begin
      wdat_mem[wdat_wp] <= app_wdf_data;
      wmsk_mem[wdat_wp] <= app_wdf_mask;
    end
  end

  // A read may only reach the BRAM once every earlier write command has committed
  assign rd_direct  = rd_acc & wcmd_empty;
  assign hold_issue = rd_hold_vld & wcmd_empty;
  assign issue      = rd_direct | hold_issue;
  assign issue_idx  = rd_hold_vld ? rd_hold_idx : acc_idx;

  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      rd_hold_vld <= 1'b0;
      rd_hold_idx <= '0;
    end else if (rd_acc & ~wcmd_empty) begin
      rd_hold_vld <= 1'b1;
      rd_hold_idx <= acc_idx;
    end else if (hold_issue) begin
      rd_hold_vld <= 1'b0;
    end
  end

  logic [MEM_DATA_BITS-1:0] ram [DEPTH];
  logic [MEM_DATA_BITS-1:0] ram_q;
  logic [DEPTH_LOG2-1:0]    commit_idx;
  logic [MEM_DATA_BITS-1:0] commit_data;
  logic [BYTES-1:0]         commit_mask;

  assign commit_idx  = wcmd_mem[wcmd_rp];
  assign commit_data = wdat_mem[wdat_rp];
  assign commit_mask = wmsk_mem[wdat_rp];

  always_ff @(posedge mem_clk) begin
    if (commit) begin
      for (int b = 0; b < BYTES; b++) begin
        if (!commit_mask[b]) ram[commit_idx][b*8 +: 8] <= commit_data[b*8 +: 8];
      end
    end
    if (issue) ram_q <= ram[issue_idx];
  end

  // rd_vld[k] and rd_pipe[k] describe the same read; ram_q pairs with rd_vld[0]
  logic [RD_LATENCY-1:0]    rd_vld;
  logic [MEM_DATA_BITS-1:0] rd_pipe [1:RD_LATENCY-1];

  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      rd_vld <= '0;
      for (int s = 1; s < RD_LATENCY; s++) rd_pipe[s] <= '0;
    end else begin
      rd_vld     <= {rd_vld[RD_LATENCY-2:0], issue};
      rd_pipe[1] <= ram_q;
      for (int s = 2; s < RD_LATENCY; s++) rd_pipe[s] <= rd_pipe[s-1];
    end
  end

  assign app_rd_data       = rd_pipe[RD_LATENCY-1];
  assign app_rd_data_valid = rd_vld[RD_LATENCY-1];
  assign app_rd_data_end   = rd_vld[RD_LATENCY-1];

endmodule

// File: tb/tb_mig_app_bram_responder.sv
// Directed bench for mig_app_bram_responder; expected read data is queued at read acceptance
// and a monitor compares each returned beat in order.
module tb_mig_app_bram_responder;

  localparam int DW = 256;
  localparam int AW = 29;
  localparam int BW = DW / 8;

  logic          mem_clk = 1'b0;
  logic          rst;
  logic          init_calib_complete;
  logic [AW-1:0] app_addr;
  logic [2:0]    app_cmd;
  logic          app_en;
  logic          app_rdy;
  logic [DW-1:0] app_wdf_data;
  logic [BW-1:0] app_wdf_mask;
  logic          app_wdf_wren;
  logic          app_wdf_end;
  logic          app_wdf_rdy;
  logic [DW-1:0] app_rd_data;
  logic          app_rd_data_valid;
  logic          app_rd_data_end;

  always #5 mem_clk = ~mem_clk;

  mig_app_bram_responder #(.RDY_STALL_PERIOD(3)) dut (
    .mem_clk(mem_clk), .rst(rst), .init_calib_complete(init_calib_complete),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask), .app_wdf_wren(app_wdf_wren),
    .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data),
    .app_rd_data_valid(app_rd_data_valid), .app_rd_data_end(app_rd_data_end)
  );

  typedef struct {logic [DW-1:0] data; int due;} exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_valid = 0;
  int last_wr_cc = -100;
  int last_wr_commit = -100;

  always @(posedge mem_clk) cyc <= cyc + 1;

  task automatic chk_vec(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge mem_clk) begin : monitor
    exp_t e;
    if (app_rd_data_valid) begin
      n_valid++;
      chk_int("rd_data_end", int'(app_rd_data_end), 1);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rd_valid: got valid at cycle %0d, expected no read outstanding", cyc);
      end else begin
        e = sb.pop_front();
        chk_vec("rd_data", app_rd_data, e.data);
        if (e.due >= 0) chk_int("rd_latency_cycle", cyc, e.due);
      end
    end
  end

  // Holds each requested handshake until accepted; called and returns at 1ns after a rising edge.
  task automatic drive(input bit do_cmd, input logic [2:0] cmd, input logic [AW-1:0] addr,
                       input bit do_dat, input logic [DW-1:0] data, input logic [BW-1:0] mask,
                       output int cmd_cyc, output int dat_cyc);
    bit cdone = !do_cmd;
    bit ddone = !do_dat;
    int n = 0;
    cmd_cyc = -1;
    dat_cyc = -1;
    app_en = do_cmd; app_cmd = cmd; app_addr = addr;
    app_wdf_wren = do_dat; app_wdf_data = data; app_wdf_mask = mask; app_wdf_end = do_dat;
    while (!(cdone && ddone)) begin
      @(negedge mem_clk);
      if (!cdone && app_rdy) begin cdone = 1; cmd_cyc = cyc; end
      if (!ddone && app_wdf_rdy) begin ddone = 1; dat_cyc = cyc; end
      @(posedge mem_clk); #1;
      if (cdone) app_en = 1'b0;
      if (ddone) app_wdf_wren = 1'b0;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL handshake_timeout: cmd_done=%0d dat_done=%0d after %0d cycles, expected both", cdone, ddone, n);
        app_en = 1'b0;
        app_wdf_wren = 1'b0;
        break;
      end
    end
  endtask

  task automatic wr(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [BW-1:0] mask);
    int cc, dc;
    drive(1, 3'b000, addr, 1, data, mask, cc, dc);
    last_wr_cc = cc;
    last_wr_commit = ((cc > dc) ? cc : dc) + 1;
  endtask

  task automatic wr_cmd(input logic [AW-1:0] addr);
    int cc, dc;
    drive(1, 3'b000, addr, 0, '0, '0, cc, dc);
  endtask

  task automatic wr_dat(input logic [DW-1:0] data, input logic [BW-1:0] mask);
    int cc, dc;
    drive(0, 3'b000, '0, 1, data, mask, cc, dc);
  endtask

  // chk_lat is only used right after an isolated single write (or when idle)
  task automatic rd(input logic [AW-1:0] addr, input logic [DW-1:0] exp, input bit chk_lat, output int acc);
    int dc;
    exp_t e;
    drive(1, 3'b001, addr, 0, '0, '0, acc, dc);
    e.data = exp;
    if (!chk_lat) e.due = -1;
    else if (acc >= last_wr_cc + 1 && acc <= last_wr_commit) e.due = last_wr_commit + 1 + 4;
    else e.due = acc + 4;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge mem_clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin idle(1); n++; end
    chk_int("drain_outstanding", sb.size(), 0);
  endtask

  // Entered 1ns after the edge at which reset was released
  task automatic calib_seq();
    for (int k = 0; k <= 66; k++) begin
      @(negedge mem_clk);
      chk_int($sformatf("calib_k%0d", k), int'(init_calib_complete), (k >= 64) ? 1 : 0);
      if (k < 64) begin
        chk_int("rdy_before_calib", int'(app_rdy), 0);
        chk_int("wdf_rdy_before_calib", int'(app_wdf_rdy), 0);
      end
    end
    @(posedge mem_clk); #1;
  endtask

  logic [DW-1:0] dv [4];
  logic [DW-1:0] pa5, p1122, pee, exp_m, pq, p99, p5a;

  initial begin
    int acc, acc_first, acc_last, cc, dc, p, nv0;
    logic [8:0] rdy_act, rdy_exp;
    logic [AW-1:0] rd_addrs [8];
    logic [DW-1:0] rd_exps [8];

    rst = 1'b1; app_addr = '0; app_cmd = '0; app_en = 1'b0;
    app_wdf_data = '0; app_wdf_mask = '0; app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
    pa5 = {BW{8'hA5}};
    p1122 = {8{32'h1122_3344}};
    pee = {BW{8'hEE}};
    exp_m = p1122;
    exp_m[7:0] = 8'hEE;
    pq = {BW{8'h77}};
    p99 = {BW{8'h99}};
    p5a = {BW{8'h5A}};
    for (int i = 0; i < 4; i++) dv[i] = {8{32'hC0DE_0000 + 32'(i)}};

    // reset state and calibration
    repeat (3) @(posedge mem_clk); #1;
    chk_int("rst_calib", int'(init_calib_complete), 0);
    chk_int("rst_rdy", int'(app_rdy), 0);
    chk_int("rst_wdf_rdy", int'(app_wdf_rdy), 0);
    chk_int("rst_valid", int'(app_rd_data_valid), 0);
    chk_vec("rst_rd_data", app_rd_data, '0);
    rst = 1'b0;
    calib_seq();

    // write with coincident data, then read straight behind it
    wr(29'h40, pa5, '0);
    rd(29'h40, pa5, 1, acc);
    drain();

    // data ahead of commands fills the data FIFO
    for (int i = 0; i < 4; i++) wr_dat(dv[i], '0);
    @(negedge mem_clk);
    chk_int("wdf_rdy_full", int'(app_wdf_rdy), 0);
    @(posedge mem_clk); #1;
    app_wdf_data = p99; app_wdf_mask = '0; app_wdf_wren = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge mem_clk);
      chk_int("wdf_rdy_5th", int'(app_wdf_rdy), 0);
      @(posedge mem_clk); #1;
    end
    app_wdf_wren = 1'b0;
    for (int i = 0; i < 4; i++) wr_cmd(29'h100 + AW'(8 * i));
    idle(3);
    @(negedge mem_clk);
    chk_int("wdf_rdy_drained", int'(app_wdf_rdy), 1);
    @(posedge mem_clk); #1;
    for (int i = 0; i < 4; i++) rd(29'h100 + AW'(8 * i), dv[i], 0, acc);
    drain();
    idle(10);
    rd(29'h2105, dv[0], 1, acc);
    drain();

    // partial-byte write
    wr(29'h200, p1122, '0);
    wr(29'h200, pee, 32'hFFFF_FFFE);
    rd(29'h200, exp_m, 0, acc);
    drain();

    // command ahead of data: the read must wait for the data
    wr_cmd(29'h300);
    rd(29'h300, pq, 0, acc);
    for (int i = 0; i < 4; i++) begin
      @(negedge mem_clk);
      chk_int("rdy_read_blocked", int'(app_rdy), 0);
      @(posedge mem_clk); #1;
    end
    chk_int("no_return_while_blocked", sb.size(), 1);
    wr_dat(pq, '0);
    drain();

    // undefined command: accepted, no response, no write
    drive(1, 3'b011, 29'h40, 0, '0, '0, cc, dc);
    idle(8);

    // ready stall pattern while idle
    for (int i = 0; i < 9; i++) begin
      @(negedge mem_clk);
      rdy_act[i] = app_rdy;
      @(posedge mem_clk); #1;
    end
    p = 0;
    for (int i = 8; i >= 0; i--) if (!rdy_act[i]) p = i;
    for (int i = 0; i < 9; i++) rdy_exp[i] = ((i % 3) != (p % 3));
    chk_int("rdy_stall_pattern", int'(rdy_act), int'(rdy_exp));

    // back-to-back reads across stalls
    rd_addrs = '{29'h100, 29'h108, 29'h110, 29'h118, 29'h40, 29'h200, 29'h300, 29'h2105};
    rd_exps  = '{dv[0], dv[1], dv[2], dv[3], pa5, exp_m, pq, dv[0]};
    acc_first = 0;
    acc_last = 0;
    for (int i = 0; i < 8; i++) begin
      rd(rd_addrs[i], rd_exps[i], 0, acc);
      if (i == 0) acc_first = acc;
      acc_last = acc;
    end
    chk_int("b2b_span_ok", ((acc_last - acc_first + 1) >= 11 && (acc_last - acc_first + 1) <= 12) ? 1 : 0, 1);
    drain();

    // reset with two reads in flight and write data pending
    drive(1, 3'b001, 29'h40, 0, '0, '0, cc, dc);
    drive(1, 3'b001, 29'h100, 1, p99, '0, cc, dc);
    nv0 = n_valid;
    rst = 1'b1;
    #1;
    chk_int("mid_rst_valid", int'(app_rd_data_valid), 0);
    chk_int("mid_rst_calib", int'(init_calib_complete), 0);
    chk_int("mid_rst_rdy", int'(app_rdy), 0);
    chk_int("mid_rst_wdf_rdy", int'(app_wdf_rdy), 0);
    repeat (3) @(posedge mem_clk); #1;
    rst = 1'b0;
    calib_seq();
    chk_int("no_valid_after_rst", n_valid, nv0);
    wr(29'h400, p5a, '0);
    rd(29'h400, p5a, 1, acc);
    rd(29'h100, dv[0], 0, acc);
    drain();
    idle(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
